// File: rtl/arbitro_em_anel.sv
// Round-robin arbiter with a one-hot rotating priority token and a registered one-hot grant.
// Optional hold limit enabled by defining ARB_TIMEOUT_EN (MAX_HOLD cycles per grant).
module arbitro_em_anel #(
    parameter int NREQ     = 4,
    parameter int MAX_HOLD = 8
) (
    input  logic            clk,
    input  logic            reset_n,
    input  logic [NREQ-1:0] req,
    output logic [NREQ-1:0] grant,
    output logic [NREQ-1:0] ptr,
    output logic            busy,
    output logic            timeout
);

    typedef enum logic {IDLE, GRANT} state_t;

    localparam logic [NREQ-1:0] ONE = NREQ'(1);

    state_t          state_reg;
    logic [NREQ-1:0] grant_reg;
    logic [NREQ-1:0] ptr_reg;

    logic [NREQ-1:0] masked_req;
    logic [NREQ-1:0] pick_src;
    logic [NREQ-1:0] pick;
    logic [NREQ-1:0] ptr_rot;
    logic            owner_req;
    logic            ptr_ok;
    logic            grant_ok;

`ifdef ARB_TIMEOUT_EN
    localparam int HW = $clog2(MAX_HOLD + 1);
    localparam logic [HW-1:0] HOLD_LAST = HW'(MAX_HOLD - 1);
    logic [HW-1:0] hold_reg;
    logic          timeout_reg;
    assign timeout = timeout_reg;
`else
    assign timeout = 1'b0;
`endif

    // Circular search: requesters at or above the token first, else wrap to the lowest one.
    always_comb begin
        masked_req = req & ~(ptr_reg - ONE);
        pick_src   = (|masked_req) ? masked_req : req;
        pick       = pick_src & (~pick_src + ONE);
        owner_req  = |(req & grant_reg);
        ptr_rot    = {grant_reg[NREQ-2:0], grant_reg[NREQ-1]};
        ptr_ok     = (ptr_reg != '0) && ((ptr_reg & (ptr_reg - ONE)) == '0);
        if (state_reg == IDLE)
            grant_ok = (grant_reg == '0);
        else
            grant_ok = (grant_reg != '0) && ((grant_reg & (grant_reg - ONE)) == '0);
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_reg   <= IDLE;
            grant_reg   <= '0;
            ptr_reg     <= ONE;
`ifdef ARB_TIMEOUT_EN
            hold_reg    <= '0;
            timeout_reg <= 1'b0;
`endif
        end else if (!ptr_ok || !grant_ok) begin
            state_reg   <= IDLE;
            grant_reg   <= '0;
            ptr_reg     <= ONE;
`ifdef ARB_TIMEOUT_EN
            hold_reg    <= '0;
            timeout_reg <= 1'b0;
`endif
        end else begin
`ifdef ARB_TIMEOUT_EN
            timeout_reg <= 1'b0;
`endif
            case (state_reg)
                IDLE: begin
                    if (|req) begin
                        grant_reg <= pick;
                        state_reg <= GRANT;
`ifdef ARB_TIMEOUT_EN
                        hold_reg  <= '0;
`endif
                    end
                end
                GRANT: begin
                    if (!owner_req) begin
                        grant_reg <= '0;
                        ptr_reg   <= ptr_rot;
                        state_reg <= IDLE;
                    end
`ifdef ARB_TIMEOUT_EN
                    // Release wins over the limit when both happen on the same edge.
                    else if (hold_reg == HOLD_LAST) begin
                        grant_reg   <= '0;
                        ptr_reg     <= ptr_rot;
                        state_reg   <= IDLE;
                        timeout_reg <= 1'b1;
                    end else begin
                        hold_reg <= hold_reg + 1'b1;
                    end
`endif
                end
                default: state_reg <= IDLE;
            endcase
        end
    end

    assign grant = grant_reg;
    assign ptr   = ptr_reg;
    assign busy  = |grant_reg;

endmodule

// File: tb/tb_arbitro_em_anel.sv
// Directed plus randomized bench for arbitro_em_anel against an index-based round-robin model.
module tb_arbitro_em_anel;

    localparam int NREQ     = 4;
    localparam int MAX_HOLD = 4;

    logic            clk = 1'b0;
    logic            reset_n = 1'b0;
    logic [NREQ-1:0] req = '0;
    logic [NREQ-1:0] grant;
    logic [NREQ-1:0] ptr;
    logic            busy;
    logic            timeout;

    int checks = 0;
    int errors = 0;

    // Reference model: owner index (-1 when free), token index, hold cycles, timeout pulse.
    int   m_owner = -1;
    int   m_ptr   = 0;
    int   m_hold  = 0;
    logic m_to    = 1'b0;

    arbitro_em_anel #(.NREQ(NREQ), .MAX_HOLD(MAX_HOLD)) dut (
        .clk(clk), .reset_n(reset_n), .req(req),
        .grant(grant), .ptr(ptr), .busy(busy), .timeout(timeout)
    );

    always #5 clk = ~clk;

    task automatic model_reset();
        m_owner = -1;
        m_ptr   = 0;
        m_hold  = 0;
        m_to    = 1'b0;
    endtask

    task automatic model_edge(input logic [NREQ-1:0] r);
        bit found;
        m_to = 1'b0;
        if (m_owner < 0) begin
            found = 0;
            for (int k = 0; k < NREQ; k++) begin
                int i;
                i = (m_ptr + k) % NREQ;
                if (!found && r[i]) begin
                    found   = 1;
                    m_owner = i;
                    m_hold  = 0;
                end
            end
        end else if (!r[m_owner]) begin
            m_ptr   = (m_owner + 1) % NREQ;
            m_owner = -1;
        end
`ifdef ARB_TIMEOUT_EN
        else if (m_hold + 1 == MAX_HOLD) begin
            m_ptr   = (m_owner + 1) % NREQ;
            m_owner = -1;
            m_to    = 1'b1;
        end
`endif
        else begin
            m_hold++;
        end
    endtask

    task automatic check(input string tag);
        logic [NREQ-1:0] eg;
        logic [NREQ-1:0] ep;
        eg = (m_owner < 0) ? '0 : (NREQ'(1) << m_owner);
        ep = NREQ'(1) << m_ptr;
        checks++;
        assert (grant === eg) else begin
            errors++;
            $error("FAIL %s grant got %b exp %b", tag, grant, eg);
        end
        checks++;
        assert (ptr === ep) else begin
            errors++;
            $error("FAIL %s ptr got %b exp %b", tag, ptr, ep);
        end
        checks++;
        assert (busy === (m_owner >= 0)) else begin
            errors++;
            $error("FAIL %s busy got %b exp %b", tag, busy, (m_owner >= 0));
        end
        checks++;
        assert (timeout === m_to) else begin
            errors++;
            $error("FAIL %s timeout got %b exp %b", tag, timeout, m_to);
        end
        $display("%s req=%b grant=%b ptr=%b busy=%b timeout=%b", tag, req, grant, ptr, busy, timeout);
    endtask

    task automatic expect_val(input string tag, input logic [NREQ-1:0] got, input logic [NREQ-1:0] exp);
        checks++;
        assert (got === exp) else begin
            errors++;
            $error("FAIL %s got %b exp %b", tag, got, exp);
        end
    endtask

    task automatic step(input logic [NREQ-1:0] r, input string tag);
        req = r;
        @(posedge clk);
        model_edge(r);
        #1;
        check(tag);
    endtask

    // Asserts reset mid-cycle, checks the asynchronous effect, releases at the next falling edge.
    task automatic areset(input string tag);
        #2;
        reset_n = 1'b0;
        #1;
        model_reset();
        check(tag);
        expect_val({tag, "_ptr"}, ptr, 4'b0001);
        @(negedge clk);
        reset_n = 1'b1;
    endtask

    initial begin
        logic [NREQ-1:0] r;
        // Power-on reset
        @(negedge clk);
        @(negedge clk);
        check("por");
        expect_val("por_grant", grant, 4'b0000);
        reset_n = 1'b1;

        // Reset mid-cycle with all requesting
        step(4'b1111, "req_all");
        expect_val("req_all_grant", grant, 4'b0001);
        req = 4'b1111;
        areset("rst_mid_cycle");
        step(4'b1111, "after_rst");
        expect_val("after_rst_grant", grant, 4'b0001);

        // Fairness: each owner drops for one cycle then re-raises
        step(4'b1110, "fair1"); expect_val("fair1_g", grant, 4'b0000);
        step(4'b1111, "fair2"); expect_val("fair2_g", grant, 4'b0010);
        step(4'b1101, "fair3"); expect_val("fair3_g", grant, 4'b0000);
        step(4'b1111, "fair4"); expect_val("fair4_g", grant, 4'b0100);
        step(4'b1011, "fair5"); expect_val("fair5_g", grant, 4'b0000);
        step(4'b1111, "fair6"); expect_val("fair6_g", grant, 4'b1000);
        step(4'b0111, "fair7"); expect_val("fair7_g", grant, 4'b0000);
        step(4'b1111, "fair8"); expect_val("fair8_g", grant, 4'b0001);
        step(4'b0000, "fair_end");

        // Single request held 3 cycles
        for (int i = 0; i < 3; i++) begin
            step(4'b0100, "single");
            expect_val("single_g", grant, 4'b0100);
        end
        step(4'b0000, "single_rel");
        expect_val("single_ptr", ptr, 4'b1000);

        // Wrap-around from ptr=1000
        step(4'b0011, "wrap");
        expect_val("wrap_g", grant, 4'b0001);
        step(4'b0000, "wrap_rel");
        expect_val("wrap_ptr", ptr, 4'b0010);

        // Hold limit
        areset("rst_hold");
        step(4'b1010, "hold0");
        expect_val("hold0_g", grant, 4'b0010);
`ifdef ARB_TIMEOUT_EN
        for (int i = 1; i < MAX_HOLD; i++) begin
            step(4'b1010, "hold");
            expect_val("hold_g", grant, 4'b0010);
        end
        step(4'b1010, "hold_to");
        expect_val("hold_to_g", grant, 4'b0000);
        expect_val("hold_to_pulse", {3'b000, timeout}, 4'b0001);
        step(4'b1010, "hold_next");
        expect_val("hold_next_g", grant, 4'b1000);
`else
        for (int i = 0; i < 10; i++) begin
            step(4'b1010, "hold");
            expect_val("hold_g", grant, 4'b0010);
            expect_val("hold_no_to", {3'b000, timeout}, 4'b0000);
        end
`endif

        // Reset while requester 3 owns the resource
        step(4'b1000, "to_owner3");
        step(4'b1000, "to_owner3");
        expect_val("owner3_g", grant, 4'b1000);
        areset("rst_mid_grant");
        expect_val("rst_mid_grant_g", grant, 4'b0000);

        // Randomized traffic: requests tend to persist, occasional asynchronous reset
        r = '0;
        for (int i = 0; i < 400; i++) begin
            if ($urandom_range(0, 99) < 35)
                r = NREQ'($urandom_range(0, (1 << NREQ) - 1));
            if ($urandom_range(0, 199) == 0) begin
                req = r;
                areset("rand_rst");
            end else begin
                step(r, "rand");
            end
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/arbitro_em_anel.md
# arbitro_em_anel

Round-robin arbiter that shares one resource among NREQ requesters, using a one-hot token that rotates like a ring counter to hold the current highest priority. It sits between the requesting blocks and the shared resource (bus or unit) and issues a registered one-hot grant. A one-cycle dead slot between owners gives bus turnaround. An optional hold limit forcibly revokes a grant from an owner that holds it too long.

## Interface
- NREQ, 4: number of requesters; must be 2 or more.
- MAX_HOLD, 8: maximum grant duration in cycles; used only when ARB_TIMEOUT_EN is defined; must be 1 or more.
- clk input 1: clock; all state changes on the rising edge.
- reset_n input 1: reset, asynchronous, active-low; clears all state immediately.
- req input NREQ: level request; bit i is held high by requester i while it wants or uses the resource.
- grant output NREQ: registered grant, one-hot or zero.
- ptr output NREQ: one-hot priority token; the bit set is the requester with highest priority at the next arbitration.
- busy output 1: high while in state GRANT (equal to |grant).
- timeout output 1: one-cycle pulse when a grant is revoked by the hold limit; always 0 without ARB_TIMEOUT_EN.

## Operation
- Reset values: grant=0, ptr=1 (bit 0), busy=0, timeout=0, hold counter=0, state IDLE.
- States: IDLE and GRANT.
- IDLE with req==0:
  - Stay in IDLE; grant stays 0.
- IDLE with req!=0:
  - Select the first requester with its req bit set, searching circularly from the ptr position upward; bit NREQ-1 wraps to bit 0.
  - Load grant with that requester's one-hot bit.
  - Clear the hold counter.
  - Go to GRANT.
- GRANT:
  - The owner is the set bit of grant.
  - Requests from other requesters are ignored; they wait.
  - If req[owner]==1 (and the hold limit is not reached), grant is unchanged.
- Release (GRANT with req[owner]==0):
  - grant becomes 0.
  - ptr becomes the owner's bit rotated left by one (MSB wraps to bit 0).
  - Go to IDLE.
- Rotation rule: ptr always moves to one past the last owner, never to one past the old ptr. Skipped requesters keep their priority order.
- ptr is never 0. If any illegal encoding is reached (ptr not one-hot, grant not one-hot in GRANT), the block recovers to its reset values on the next edge.
- Reset during GRANT: grant drops to 0 asynchronously, and the token returns to bit 0.

## Timing
- req is sampled on the rising edge; there is no combinational path from req to grant.
- Request latency: request sampled high in IDLE at edge k gives grant valid after edge k.
- Release latency: owner's req sampled low at edge k gives grant=0 after edge k.
- Next grant: the next pending requester is granted after edge k+1. The minimum dead gap between owners is exactly 1 cycle.
- Sustained throughput: with every requester always pending, each owner holding for H cycles, a full round takes NREQ*(H+1) cycles.
- Hold counter width is $clog2(MAX_HOLD+1). It increments on every edge spent in GRANT.

## Configuration
- ARB_TIMEOUT_EN defined:
  - In GRANT, when the hold counter equals MAX_HOLD-1 and req[owner] is still 1 at the edge:
    - grant becomes 0 and timeout becomes 1 for that one cycle.
    - ptr rotates past the owner, as on a normal release.
    - Go to IDLE.
  - The owner's grant is therefore visible for exactly MAX_HOLD cycles.
  - A preempted requester that keeps req high competes again, now at the lowest priority.
  - If release and limit happen on the same edge, it is treated as a release: timeout=0.
- ARB_TIMEOUT_EN undefined:
  - No hold counter; timeout is tied to 0.
  - The grant is held for as long as req[owner]==1, without limit.

## Test plan
- Reset: drive reset_n=0 mid-cycle with req=1111 → grant=0000, ptr=0001, busy=0 immediately; after release, grant=0001 one edge later.
- Single request: req=0100 for 3 cycles, then 0000 → grant=0100 after the first edge and held 3 cycles; grant=0000 one edge after req drops; ptr=1000.
- Fairness: req=1111, each owner drops its req after 1 granted cycle and re-raises it → grant sequence 0001, 0000, 0010, 0000, 0100, 0000, 1000, 0000, 0001.
- Wrap-around: ptr=1000 and req=0011 in IDLE → grant=0001, then ptr=0010 after release.
- Hold limit (ARB_TIMEOUT_EN, MAX_HOLD=4): req=1010 held constant from reset → grant=0010 for 4 cycles; timeout=1 with grant=0000 for one cycle; then grant=1000. Without the macro, grant=0010 indefinitely and timeout=0.
- Reset mid-grant: assert reset_n=0 during grant=1000 → grant=0000, ptr=0001 asynchronously, before the next clock edge.
